// File: rtl/log_mem_pkg.sv
// ============================================================================
// Module      : log_mem_pkg
// Description : Shared log-memory definitions: FSM encoding, default widths
//               and the register-file memory-log command codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package log_mem_pkg;

    localparam int NB_ADDR_MEM = 15;
    localparam int NB_DATA     = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_CAPTURE = ST_CAPTURE,
        S_FULL    = ST_FULL
    } log_state_e;

    // Register-file command codes, shared so both blocks agree on one definition.
    localparam logic [7:0] CMD_RUN_MEM     = 8'd4;
    localparam logic [7:0] CMD_READ_MEM    = 8'd5;
    localparam logic [7:0] CMD_IS_MEM_FULL = 8'd12;

endpackage

`default_nettype wire

// File: rtl/log_ram.sv
// ============================================================================
// Module      : log_ram
// Description : Simple dual-port log RAM, one write port and one read port.
//               LOG_MEM_REG_READ_EN selects a registered (block-RAM) read;
//               otherwise the read is combinational (distributed RAM).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_ram #(
    parameter int NB_ADDR = 15,
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data
);

    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef LOG_MEM_REG_READ_EN
    logic [NB_DATA-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;
`else
    assign o_rd_data = r_mem[i_rd_addr];
`endif

endmodule

`default_nettype wire

// File: rtl/log_memory_ctrl.sv
// ============================================================================
// Module      : log_memory_ctrl
// Description : Capture controller for the memory-log path: fills the log RAM
//               with valid samples after a run pulse, then serves reads.
//               Read latency is set by LOG_MEM_REG_READ_EN (see log_ram).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_memory_ctrl #(
    parameter int NB_ADDR_MEM = log_mem_pkg::NB_ADDR_MEM,
    parameter int NB_DATA     = log_mem_pkg::NB_DATA
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_run_log,
    input  logic                   i_read_log,
    input  logic [NB_ADDR_MEM-1:0] i_addr_log_to_mem,
    input  logic [NB_DATA-1:0]     i_data,
    input  logic                   i_valid,
    output logic [NB_DATA-1:0]     o_data_log_to_rf,
    output logic                   o_mem_full,
    output logic                   o_capturing
);

    import log_mem_pkg::*;

    localparam logic [NB_ADDR_MEM-1:0] c_LAST_ADDR = '1;

    log_state_e             r_state;
    log_state_e             w_state_next;
    logic [NB_ADDR_MEM-1:0] r_wr_ptr;
    logic [NB_ADDR_MEM-1:0] w_wr_ptr_next;
    logic                   r_mem_full;
    logic                   w_mem_full_next;
    logic                   r_capturing;
    logic                   w_wr_en;

    // The read strobe is status only; the read path never depends on it.
    logic w_unused;
    assign w_unused = i_read_log;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_mem_full  <= 1'b0;
            r_capturing <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wr_ptr    <= w_wr_ptr_next;
            r_mem_full  <= w_mem_full_next;
            r_capturing <= (w_state_next == S_CAPTURE);
        end
    end

    // A run pulse overrides everything, including a valid sample on the same edge.
    always_comb begin
        w_state_next    = r_state;
        w_wr_ptr_next   = r_wr_ptr;
        w_mem_full_next = r_mem_full;
        w_wr_en         = 1'b0;
        if (i_run_log) begin
            w_state_next    = S_CAPTURE;
            w_wr_ptr_next   = '0;
            w_mem_full_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_CAPTURE: begin
                    if (i_valid) begin
                        w_wr_en       = 1'b1;
                        w_wr_ptr_next = r_wr_ptr + 1'b1;
                        if (r_wr_ptr == c_LAST_ADDR) begin
                            w_state_next    = S_FULL;
                            w_mem_full_next = 1'b1;
                        end
                    end
                end
                S_FULL: ;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    log_ram #(
        .NB_ADDR (NB_ADDR_MEM),
        .NB_DATA (NB_DATA)
    ) u_log_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_data),
        .i_rd_addr (i_addr_log_to_mem),
        .o_rd_data (o_data_log_to_rf)
    );

    assign o_mem_full  = r_mem_full;
    assign o_capturing = r_capturing;

endmodule

`default_nettype wire

// File: doc/log_memory_ctrl.md
# log_memory_ctrl

Capture buffer feeding the register file's memory-log path. On a one-cycle `i_run_log` pulse it clears and fills a 2^NB_ADDR_MEM-word RAM with consecutive valid samples from the datapath, then raises `o_mem_full`. Once full, it serves random-access reads at `i_addr_log_to_mem` on `o_data_log_to_rf`. The register file uses that data to answer processor log reads through GPI.

## Interface
- `NB_ADDR_MEM`, 15, log RAM address width; depth = 2^NB_ADDR_MEM.
- `NB_DATA`, 32, log word width; must equal the register file GPI width.
- `clk`  in  1  system clock, all logic on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_run_log`  in  1  one-cycle start pulse from the register file.
- `i_read_log`  in  1  read strobe from the register file; status only, does not gate the read path.
- `i_addr_log_to_mem`  in  NB_ADDR_MEM  read address, registered upstream.
- `i_data`  in  NB_DATA  sample word to log, e.g. packed I/Q.
- `i_valid`  in  1  sample qualifier / clock enable of the datapath rate.
- `o_data_log_to_rf`  out  NB_DATA  RAM word at the read address.
- `o_mem_full`  out  1  capture complete; RAM is stable and readable.
- `o_capturing`  out  1  high while in CAPTURE.

## Operation
- States:
  - IDLE: reset state.
  - CAPTURE: filling the RAM.
  - FULL: capture complete.
- Reset values: state=IDLE, `wr_ptr`=0, `o_mem_full`=0, `o_capturing`=0. `o_data_log_to_rf` is RAM-derived and not reset. RAM contents are not reset.
- `i_run_log`=1 in any state → next state CAPTURE, `wr_ptr`←0, `o_mem_full`←0.
  - This has highest priority. A capture or full condition in the same cycle is discarded, and no write occurs that cycle.
  - `i_run_log` during CAPTURE restarts the capture from address 0.
- CAPTURE with `i_valid`=1:
  - RAM[`wr_ptr`]←`i_data`, `wr_ptr`←`wr_ptr`+1.
  - If `wr_ptr`=2^NB_ADDR_MEM−1: write the last word, `wr_ptr` wraps to 0, next state FULL, `o_mem_full`←1.
- CAPTURE with `i_valid`=0: hold.
- FULL: no writes; hold until the next `i_run_log`. `i_valid` is ignored.
- IDLE: no writes; `i_valid` is ignored.
- Read path is independent of state.
  - Reads outside FULL return whatever the RAM holds: stale or uninitialised data. This is not an error.
  - The register file only issues reads when `o_mem_full`=1.
- `o_capturing` = (state==CAPTURE), registered.
- `i_read_log` has no effect on state.

## Timing
- `i_run_log` high at edge t → `o_capturing`=1 and `o_mem_full`=0 after edge t. The first possible write is at edge t+1.
- Capture of N=2^NB_ADDR_MEM samples completes on the edge of the N-th valid sample. `o_mem_full`=1 immediately after that edge.
- Default read is combinational, zero latency: `o_data_log_to_rf` = RAM[`i_addr_log_to_mem`] in the same cycle.
  - This matches the register file, which samples the data in the cycle its read strobe is high, i.e. the first cycle the new address is presented.
- Write-then-read of the same address cannot occur: writes happen only in CAPTURE, reads only in FULL.
- Asynchronous reset mid-capture: outputs return to reset values immediately. The partial RAM contents remain but are not flagged full.

## Configuration
- `LOG_MEM_REG_READ_EN` defined:
  - The RAM read becomes synchronous: output register, one-cycle latency (data for the address at edge t is valid after edge t). This maps to block RAM.
  - The register file must hold the address for two cycles before sampling.
- `LOG_MEM_REG_READ_EN` undefined: combinational read, distributed RAM, zero latency, as above.

## Structure
- Shared package `log_mem_pkg`:
  - state encoding localparams `ST_IDLE`=2'd0, `ST_CAPTURE`=2'd1, `ST_FULL`=2'd2;
  - default widths `NB_ADDR_MEM`, `NB_DATA`;
  - the register file command codes for RUN_MEM (4), READ_MEM (5) and IS_MEM_FULL (12), so both blocks share one definition.
- Sub-module `log_ram`:
  - simple dual-port memory: one write port, one read port;
  - parameters `NB_ADDR`, `NB_DATA`;
  - contains the `LOG_MEM_REG_READ_EN` read-register option.
- Top module holds the FSM, `wr_ptr` and the status outputs.

## Test plan
All cases use NB_ADDR_MEM=4, depth 16.
- Reset: hold `i_rst_n`=0 with `clk` running → `o_mem_full`=0, `o_capturing`=0. Deassert with no `i_run_log` → outputs stay 0, and 20 cycles of `i_valid`=1 write nothing.
- Full capture: pulse `i_run_log`, then `i_valid`=1 continuously with `i_data`=0x100+k → `o_mem_full` rises right after the 16th valid edge. Reading addresses 0..15 returns 0x100..0x10F. Further valid samples do not alter the contents.
- Gapped valid: `i_valid` high one cycle in three → `o_mem_full` rises after the 16th valid sample, at edge 46 after the run pulse. Contents are ordered with no gaps.
- Restart: `i_run_log` after 7 samples, asserted on the same edge as a valid sample → that sample is dropped and `wr_ptr` restarts at 0. 16 further samples are needed for full; address 0 holds the first post-restart sample.
- Re-arm from FULL: `i_run_log` in FULL → `o_mem_full` drops the next cycle and `o_capturing`=1.
- Async reset mid-capture (after 5 samples, asserted between edges) → outputs clear immediately without a clock edge. With `LOG_MEM_REG_READ_EN`, a read at address 3 shows the data one cycle after the address is applied.
